// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value and writes it into the general register file.
// Two bypassed read ports for ID, one unbypassed debug port, and a committed-write counter.
module wb_regfile #(
    parameter int unsigned    NREG    = 32,
    parameter int unsigned    DW      = 32,
    parameter logic [DW-1:0]  SP_INIT = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               MEM_WB_mem_to_reg,
    input  logic [DW-1:0]            MEM_WB_ALU_out,
    input  logic [DW-1:0]            MEM_WB_mem_rd_data,
    input  logic [DW-1:0]            MEM_WB_PC_plus_8,
    input  logic                     MEM_WB_reg_wr,
    input  logic [$clog2(NREG)-1:0]  MEM_WB_reg_wr_addr,
    input  logic [$clog2(NREG)-1:0]  rs_addr,
    input  logic [$clog2(NREG)-1:0]  rt_addr,
    output logic [DW-1:0]            rs_data,
    output logic [DW-1:0]            rt_data,
    output logic [DW-1:0]            WB_reg_wr_data,
    output logic                     WB_wr_valid,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [DW-1:0]            dbg_data,
    output logic [31:0]              wb_count
);

    localparam int unsigned AW     = $clog2(NREG);
    localparam int unsigned CW     = 32;
    localparam int unsigned SP_IDX = 29;

    logic [DW-1:0] regs_q [NREG];
    logic [CW-1:0] wb_count_q;
    logic [CW-1:0] wb_count_d;

    // Writeback source select; the reserved encoding falls back to the ALU result.
    always_comb begin
        WB_reg_wr_data = MEM_WB_ALU_out;
        case (MEM_WB_mem_to_reg)
            2'b01:   WB_reg_wr_data = MEM_WB_mem_rd_data;
            2'b10:   WB_reg_wr_data = MEM_WB_PC_plus_8;
            default: WB_reg_wr_data = MEM_WB_ALU_out;
        endcase
    end

    assign WB_wr_valid = MEM_WB_reg_wr && (MEM_WB_reg_wr_addr != AW'(0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (WB_wr_valid) begin
            regs_q[MEM_WB_reg_wr_addr] <= WB_reg_wr_data;
        end
    end

    // Read ports write through the in-flight writeback value.
    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == AW'(0)) begin
            rs_data = '0;
        end else if (WB_wr_valid && (rs_addr == MEM_WB_reg_wr_addr)) begin
            rs_data = WB_reg_wr_data;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == AW'(0)) begin
            rt_data = '0;
        end else if (WB_wr_valid && (rt_addr == MEM_WB_reg_wr_addr)) begin
            rt_data = WB_reg_wr_data;
        end
    end

    always_comb begin
        dbg_data = (dbg_addr == AW'(0)) ? '0 : regs_q[dbg_addr];
    end

    assign wb_count_d = wb_count_q + CW'(WB_wr_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_count_q <= '0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

endmodule
